// File: rtl/mtmon_pkg.sv
// Shared types and helpers for the MT timepulse sequence monitor.
// No logic of its own; the monitor and its edge detector import it.
package mtmon_pkg;

  localparam int NUM_TP = 12;

  typedef logic [3:0] tp_idx_t;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_SYNC   = 1'b1
  } mon_state_e;

  // Successor of a timepulse index, wrapping MT12 back to MT01.
  function automatic tp_idx_t next_tp(input tp_idx_t k);
    return (k == tp_idx_t'(NUM_TP)) ? tp_idx_t'(1) : tp_idx_t'(k + 4'd1);
  endfunction

endpackage

// File: rtl/mt_seq_monitor_if.sv
// Monitor-side signal bundle: MT timepulses and controls in, status and capture registers out.
// Pure wiring; the master drives the timepulses, the slave is the monitor.
interface mt_seq_monitor_if;
  import mtmon_pkg::*;

  logic MT01, MT02, MT03, MT04, MT05, MT06;
  logic MT07, MT08, MT09, MT10, MT11, MT12;
  logic MGOJAM;
  logic MSTPIT_;
  logic ERRCLR;

  tp_idx_t     TSTATE;
  logic [15:0] MCTCNT;
  logic        SEQERR;
  logic        MULTERR;
  logic        WIDERR;
  tp_idx_t     ERREXP;
  tp_idx_t     ERRGOT;
  logic        STALL;
  logic        STOPPED;

  modport master (
    output MT01, MT02, MT03, MT04, MT05, MT06,
    output MT07, MT08, MT09, MT10, MT11, MT12,
    output MGOJAM, MSTPIT_, ERRCLR,
    input  TSTATE, MCTCNT, SEQERR, MULTERR, WIDERR,
    input  ERREXP, ERRGOT, STALL, STOPPED
  );

  modport slave (
    input  MT01, MT02, MT03, MT04, MT05, MT06,
    input  MT07, MT08, MT09, MT10, MT11, MT12,
    input  MGOJAM, MSTPIT_, ERRCLR,
    output TSTATE, MCTCNT, SEQERR, MULTERR, WIDERR,
    output ERREXP, ERRGOT, STALL, STOPPED
  );

endinterface

// File: rtl/mtmon_edge.sv
// Samples the 12 MT lines and reports this cycle's rising edges as a single index or a multi-edge flag.
// Combinational from the input against the one-cycle-old sample; no backpressure.
module mtmon_edge
  import mtmon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_TP-1:0] mt,
  output logic              one,
  output logic              multi,
  output tp_idx_t           idx
);

  localparam logic [NUM_TP-1:0] LSB_ONE = {{(NUM_TP-1){1'b0}}, 1'b1};

  logic [NUM_TP-1:0] samp;
  logic              primed;
  logic [NUM_TP-1:0] rise;
  logic [NUM_TP-1:0] rise_rest;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp   <= '0;
      primed <= 1'b0;
    end else begin
      samp   <= mt;
      primed <= 1'b1;
    end
  end

  // Right after reset the sample is meaningless, so a line still high from before reset must not look like an edge.
  assign rise      = primed ? (mt & ~samp) : '0;
  assign rise_rest = rise & (rise - LSB_ONE);
  assign multi     = |rise_rest;
  assign one       = (|rise) && !multi;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (rise[i]) begin
        idx = tp_idx_t'(i + 1);
      end
    end
  end

endmodule

// File: rtl/mt_seq_monitor.sv
// Checks MT01..MT12 timepulse ordering, counts memory cycles, flags stalls; MTMON_WIDTH_EN adds pulse-width checking.
// All outputs registered, one cycle after the edge is detected; passive monitor with no backpressure.
module mt_seq_monitor
  import mtmon_pkg::*;
#(
  parameter int STALL_LIM = 16,
  parameter int WMIN      = 1,
  parameter int WMAX      = 2
)(
  input  logic           CLOCK,
  input  logic           rst,
  mt_seq_monitor_if.slave mon
);

  localparam int             SCW       = $clog2(STALL_LIM + 1);
  localparam logic [SCW-1:0] STALL_TOP = SCW'(STALL_LIM);

  logic [NUM_TP-1:0] mt_vec;
  logic              one;
  logic              multi;
  tp_idx_t           idx;

  assign mt_vec = {mon.MT12, mon.MT11, mon.MT10, mon.MT09, mon.MT08, mon.MT07,
                   mon.MT06, mon.MT05, mon.MT04, mon.MT03, mon.MT02, mon.MT01};

  mtmon_edge u_edge (
    .clk   (CLOCK),
    .rst   (rst),
    .mt    (mt_vec),
    .one   (one),
    .multi (multi),
    .idx   (idx)
  );

  mon_state_e     state_q, state_d;
  tp_idx_t        tstate_q, tstate_d;
  tp_idx_t        exp_tp;
  logic           cyc_done;
  logic           seq_ev;
  logic           mul_ev;
  logic           wid_ev;
  logic [15:0]    mct_q;
  logic           seqerr_q, multerr_q, widerr_q;
  tp_idx_t        errexp_q, errgot_q;
  logic [SCW-1:0] stall_cnt;
  logic           stall_q, stopped_q;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q  <= ST_UNSYNC;
      tstate_q <= '0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
    end
  end

  // GOJAM wins over any edge in the same cycle and is never itself an error.
  always_comb begin
    state_d  = state_q;
    tstate_d = tstate_q;
    cyc_done = 1'b0;
    seq_ev   = 1'b0;
    exp_tp   = next_tp(tstate_q);
    mul_ev   = multi && !mon.MGOJAM;
    if (mon.MGOJAM) begin
      state_d  = ST_UNSYNC;
      tstate_d = '0;
    end else if (one) begin
      case (state_q)
        ST_UNSYNC: begin
          state_d  = ST_SYNC;
          tstate_d = idx;
        end
        ST_SYNC: begin
          if (idx == exp_tp) begin
            tstate_d = idx;
            cyc_done = (tstate_q == tp_idx_t'(NUM_TP));
          end else begin
            seq_ev   = 1'b1;
            state_d  = ST_UNSYNC;
            tstate_d = '0;
          end
        end
        default: begin
          state_d  = ST_UNSYNC;
          tstate_d = '0;
        end
      endcase
    end
  end

`ifdef MTMON_WIDTH_EN
  localparam int WCW = $clog2(WMAX + 2);

  logic [WCW-1:0]    hi_cnt [NUM_TP];
  logic [NUM_TP-1:0] wid_line;

  // High-time counters stop at WMAX+1, which is enough to know the limit was exceeded.
  always_ff @(posedge CLOCK) begin
    for (int i = 0; i < NUM_TP; i++) begin
      if (rst || !mt_vec[i]) begin
        hi_cnt[i] <= '0;
      end else if (int'(hi_cnt[i]) <= WMAX) begin
        hi_cnt[i] <= hi_cnt[i] + WCW'(1);
      end
    end
  end

  always_comb begin
    wid_line = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (mt_vec[i]) begin
        wid_line[i] = (int'(hi_cnt[i]) >= WMAX);
      end else begin
        wid_line[i] = (hi_cnt[i] != '0) && (int'(hi_cnt[i]) < WMIN);
      end
    end
  end

  assign wid_ev = |wid_line;
`else
  assign wid_ev = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      mct_q     <= '0;
      seqerr_q  <= 1'b0;
      multerr_q <= 1'b0;
      widerr_q  <= 1'b0;
      errexp_q  <= '0;
      errgot_q  <= '0;
    end else begin
      if (cyc_done && (mct_q != 16'hFFFF)) begin
        mct_q <= mct_q + 16'd1;
      end
      seqerr_q  <= (seqerr_q  && !mon.ERRCLR) || seq_ev;
      multerr_q <= (multerr_q && !mon.ERRCLR) || mul_ev;
      widerr_q  <= (widerr_q  && !mon.ERRCLR) || wid_ev;
      // Capture only the first sequence error; a clear in the same cycle re-arms it.
      if (seq_ev && (!seqerr_q || mon.ERRCLR)) begin
        errexp_q <= exp_tp;
        errgot_q <= idx;
      end else if (mon.ERRCLR) begin
        errexp_q <= '0;
        errgot_q <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      stall_q   <= (stall_cnt == STALL_TOP) &&  mon.MSTPIT_;
      stopped_q <= (stall_cnt == STALL_TOP) && !mon.MSTPIT_;
      if (mon.MGOJAM || one) begin
        stall_cnt <= '0;
      end else if (!multi && (stall_cnt != STALL_TOP)) begin
        stall_cnt <= stall_cnt + SCW'(1);
      end
    end
  end

  assign mon.TSTATE  = tstate_q;
  assign mon.MCTCNT  = mct_q;
  assign mon.SEQERR  = seqerr_q;
  assign mon.MULTERR = multerr_q;
  assign mon.WIDERR  = widerr_q;
  assign mon.ERREXP  = errexp_q;
  assign mon.ERRGOT  = errgot_q;
  assign mon.STALL   = stall_q;
  assign mon.STOPPED = stopped_q;

endmodule

// File: tb/tb_mt_seq_monitor.sv
// Scoreboard bench for mt_seq_monitor: directed scenarios plus random timepulse traffic against a reference model.
`timescale 1ns/1ps
module tb_mt_seq_monitor;

  localparam int STALL_LIM = 16;
  localparam int WMIN      = 1;
  localparam int WMAX      = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mt_v;
  bit          sp;

  always #5 clk = ~clk;

  mt_seq_monitor_if mif();

  assign mif.MT01 = mt_v[0];
  assign mif.MT02 = mt_v[1];
  assign mif.MT03 = mt_v[2];
  assign mif.MT04 = mt_v[3];
  assign mif.MT05 = mt_v[4];
  assign mif.MT06 = mt_v[5];
  assign mif.MT07 = mt_v[6];
  assign mif.MT08 = mt_v[7];
  assign mif.MT09 = mt_v[8];
  assign mif.MT10 = mt_v[9];
  assign mif.MT11 = mt_v[10];
  assign mif.MT12 = mt_v[11];

  mt_seq_monitor #(.STALL_LIM(STALL_LIM), .WMIN(WMIN), .WMAX(WMAX)) dut (
    .CLOCK (clk),
    .rst   (rst),
    .mon   (mif)
  );

  typedef struct {
    int ts; int mct; int seq; int mul; int wid; int eexp; int egot; int stall; int stop;
  } exp_t;

  exp_t sbq[$];
  int   ntot = 0;
  int   nbad = 0;

  // Reference model state, in terms of the observable behaviour.
  int         m_ts, m_mct, m_seq, m_mul, m_wid, m_exp, m_got, m_quiet, m_stall, m_stop;
  logic [11:0] m_prev;
  bit         m_primed;
  int         m_hi [12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_cycle(input logic [11:0] mt, input bit gj, input bit sp_i, input bit clr, input bit r);
    int rises[$];
    int k, e_exp, e_got;
    bit seq_ev, mul_ev, wid_ev;
    seq_ev = 0; mul_ev = 0; wid_ev = 0; e_exp = 0; e_got = 0;
    if (r) begin
      m_ts = 0; m_mct = 0; m_seq = 0; m_mul = 0; m_wid = 0; m_exp = 0; m_got = 0;
      m_quiet = 0; m_stall = 0; m_stop = 0; m_prev = '0; m_primed = 0;
      foreach (m_hi[i]) m_hi[i] = 0;
      return;
    end
    for (int i = 0; i < 12; i++)
      if (m_primed && mt[i] && !m_prev[i]) rises.push_back(i + 1);
    m_stall = (m_quiet == STALL_LIM) &&  sp_i;
    m_stop  = (m_quiet == STALL_LIM) && !sp_i;
    if (gj) begin
      m_ts = 0; m_quiet = 0;
    end else if (rises.size() == 1) begin
      k = rises[0];
      m_quiet = 0;
      if (m_ts == 0) m_ts = k;
      else begin
        e_exp = (m_ts == 12) ? 1 : m_ts + 1;
        if (k == e_exp) begin
          if (m_ts == 12 && m_mct < 65535) m_mct++;
          m_ts = k;
        end else begin
          seq_ev = 1; e_got = k; m_ts = 0;
        end
      end
    end else if (rises.size() > 1) begin
      mul_ev = 1;
    end else if (m_quiet < STALL_LIM) begin
      m_quiet++;
    end
`ifdef MTMON_WIDTH_EN
    for (int i = 0; i < 12; i++) begin
      if (mt[i]) begin
        m_hi[i]++;
        if (m_hi[i] > WMAX) wid_ev = 1;
      end else begin
        if (m_hi[i] > 0 && m_hi[i] < WMIN) wid_ev = 1;
        m_hi[i] = 0;
      end
    end
`endif
    if (seq_ev && (!m_seq || clr)) begin
      m_exp = e_exp; m_got = e_got;
    end else if (clr) begin
      m_exp = 0; m_got = 0;
    end
    m_seq = int'((m_seq != 0 && !clr) || seq_ev);
    m_mul = int'((m_mul != 0 && !clr) || mul_ev);
    m_wid = int'((m_wid != 0 && !clr) || wid_ev);
    m_prev = mt;
    m_primed = 1;
  endtask

  task automatic step(input logic [11:0] mt, input bit gj, input bit clr, input bit r);
    exp_t e;
    @(negedge clk);
    mt_v = mt; mif.MGOJAM = gj; mif.MSTPIT_ = sp; mif.ERRCLR = clr; rst = r;
    model_cycle(mt, gj, sp, clr, r);
    e.ts = m_ts; e.mct = m_mct; e.seq = m_seq; e.mul = m_mul; e.wid = m_wid;
    e.eexp = m_exp; e.egot = m_got; e.stall = m_stall; e.stop = m_stop;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(12'h000, 0, 0, 0);
  endtask

  task automatic pulse(input logic [11:0] m, input int w, input bit gj, input bit clr);
    for (int c = 0; c < w; c++) step(m, gj && (c == 0), clr && (c == 0), 0);
  endtask

  function automatic logic [11:0] tp_mask(input int k);
    logic [11:0] one_v;
    one_v = 12'h001;
    return one_v << (k - 1);
  endfunction

  // Monitor: every cycle the driver issued yields one registered response to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_TSTATE",  mif.TSTATE,  e.ts);
        chk("sb_MCTCNT",  mif.MCTCNT,  e.mct);
        chk("sb_SEQERR",  mif.SEQERR,  e.seq);
        chk("sb_MULTERR", mif.MULTERR, e.mul);
        chk("sb_WIDERR",  mif.WIDERR,  e.wid);
        chk("sb_ERREXP",  mif.ERREXP,  e.eexp);
        chk("sb_ERRGOT",  mif.ERRGOT,  e.egot);
        chk("sb_STALL",   mif.STALL,   e.stall);
        chk("sb_STOPPED", mif.STOPPED, e.stop);
      end
    end
  end

  initial begin
    #500000;
    nbad++;
    $display("FAIL timeout: bench still running at %0t, expected completion", $time);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    int g, r, w, a, b, n;
    rst = 1'b1; mt_v = '0; sp = 1; mif.MGOJAM = 0; mif.MSTPIT_ = 1; mif.ERRCLR = 0;

    step(12'h000, 0, 0, 1);
    step(12'h000, 0, 0, 1);
    idle();
    @(posedge clk); #2;
    chk("reset_TSTATE", mif.TSTATE, 0);
    chk("reset_MCTCNT", mif.MCTCNT, 0);

    // Three full rounds in order: first MT01 only syncs, so two completed cycles.
    for (int rr = 0; rr < 3; rr++)
      for (int k = 1; k <= 12; k++) step(tp_mask(k), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("rounds_TSTATE", mif.TSTATE, 12);
    chk("rounds_MCTCNT", mif.MCTCNT, 2);
    chk("rounds_SEQERR", mif.SEQERR, 0);

    step(12'h000, 1, 0, 0);
    step(tp_mask(1), 0, 0, 0);
    step(tp_mask(2), 0, 0, 0);
    step(tp_mask(3), 0, 0, 0);
    step(tp_mask(5), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("skip_SEQERR", mif.SEQERR, 1);
    chk("skip_ERREXP", mif.ERREXP, 4);
    chk("skip_ERRGOT", mif.ERRGOT, 5);
    chk("skip_TSTATE", mif.TSTATE, 0);
    step(tp_mask(6), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("resync_TSTATE", mif.TSTATE, 6);
    chk("resync_ERRGOT", mif.ERRGOT, 5);
    step(12'h000, 0, 1, 0);

    step(tp_mask(3) | tp_mask(7), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("multi_MULTERR", mif.MULTERR, 1);
    chk("multi_TSTATE", mif.TSTATE, 6);
    step(12'h000, 0, 1, 0);
    idle();
    @(posedge clk); #2;
    chk("clr_MULTERR", mif.MULTERR, 0);

    step(12'h000, 1, 0, 0);
    for (int k = 1; k <= 5; k++) step(tp_mask(k), 0, 0, 0);
    step(tp_mask(6), 1, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("gojam_TSTATE", mif.TSTATE, 0);
    chk("gojam_SEQERR", mif.SEQERR, 0);
    step(tp_mask(9), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("after_gojam_TSTATE", mif.TSTATE, 9);
    chk("after_gojam_SEQERR", mif.SEQERR, 0);

    sp = 1;
    repeat (20) idle();
    @(posedge clk); #2;
    chk("idle_STALL", mif.STALL, 1);
    sp = 0;
    repeat (20) idle();
    @(posedge clk); #2;
    chk("idle_STOPPED", mif.STOPPED, 1);
    chk("idle_STALL_low", mif.STALL, 0);
    step(tp_mask(10), 0, 0, 0);
    idle();
    @(posedge clk); #2;
    chk("edge_STALL", mif.STALL, 0);
    chk("edge_STOPPED", mif.STOPPED, 0);
    sp = 1;

    pulse(tp_mask(4), 3, 0, 0);
    idle();
    @(posedge clk); #2;
`ifdef MTMON_WIDTH_EN
    chk("long_WIDERR", mif.WIDERR, 1);
`else
    chk("long_WIDERR", mif.WIDERR, 0);
`endif

    // Random traffic: mostly in-order pulses, with skips, collisions, GOJAMs, clears, stalls and resets.
    step(12'h000, 0, 0, 1);
    g = 0;
    repeat (500) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        g = (g % 12) + 1;
        w = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(1, 2);
        pulse(tp_mask(g), w, 0, $urandom_range(0, 29) == 0);
        n = $urandom_range(0, 1);
        repeat (n) idle();
      end else if (r < 78) begin
        g = $urandom_range(1, 12);
        pulse(tp_mask(g), $urandom_range(1, 2), 0, 0);
      end else if (r < 84) begin
        a = $urandom_range(1, 12);
        b = (a % 12) + $urandom_range(1, 10);
        if (b > 12) b = b - 12;
        pulse(tp_mask(a) | tp_mask(b), 1, $urandom_range(0, 3) == 0, 0);
      end else if (r < 88) begin
        g = (g % 12) + 1;
        pulse(tp_mask(g), 1, 1, 0);
      end else if (r < 92) begin
        step(12'h000, 0, 1, 0);
      end else if (r < 95) begin
        sp = bit'($urandom_range(0, 1));
        n = $urandom_range(15, 22);
        repeat (n) idle();
      end else if (r < 97) begin
        step(12'h000, 0, $urandom_range(0, 1) == 1, 1);
        g = 0;
      end else begin
        sp = ~sp;
        idle();
      end
    end
    idle();

    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    ntot++;
    if (sbq.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/mt_seq_monitor.md
MT_SEQ_MONITOR -- requirements
Module: mt_seq_monitor

Interface
REQ-001 Parameter STALL_LIM, default 16: CLOCK cycles with no MT rising edge before STALL is asserted.
REQ-002 Parameter WMIN, default 1: minimum MT pulse width in CLOCK cycles (width check only).
REQ-003 Parameter WMAX, default 2: maximum MT pulse width in CLOCK cycles (width check only).
REQ-004 CLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 MT01..MT12  in  1 each  monitor timepulses from the timer module.
REQ-007 MGOJAM  in  1  monitor GOJAM; forces resynchronisation.
REQ-008 MSTPIT_  in  1  monitor stop indication, low = timer stop requested.
REQ-009 ERRCLR  in  1  synchronous clear of sticky error flags and capture registers.
REQ-010 TSTATE  out  4  last accepted timepulse, 1..12; 0 = unsynchronised.
REQ-011 MCTCNT  out  16  completed memory cycles, saturating.
REQ-012 SEQERR  out  1  sticky out-of-order flag.
REQ-013 MULTERR  out  1  sticky flag: two or more MT lines rose in the same cycle.
REQ-014 WIDERR  out  1  sticky pulse-width violation flag.
REQ-015 ERREXP / ERRGOT  out  4 each  expected and received index of the first SEQERR.
REQ-016 STALL  out  1  no MT edge for STALL_LIM cycles while MSTPIT_ is high.
REQ-017 STOPPED  out  1  no MT edge for STALL_LIM cycles while MSTPIT_ is low.

Function
REQ-018 Sample MT01..MT12 each cycle into a register; rising edge = current sample high and previous sample low.
REQ-019 Exactly one rising edge in a cycle: encode it to index k (1..12).
REQ-020 Zero rising edges in a cycle: no sequence action.
REQ-021 Two or more rising edges in a cycle: set MULTERR; TSTATE, MCTCNT and the stall counter are unchanged.
REQ-022 States: UNSYNC (TSTATE=0) and SYNC.
REQ-023 UNSYNC: first single edge k sets TSTATE=k, moves to SYNC, raises no error and does not count.
REQ-024 SYNC: expected index = TSTATE+1, with 12 wrapping to 1.
REQ-025 SYNC, k equals expected: TSTATE<=k; if the transition is 12->1, MCTCNT increments by 1, saturating at 16'hFFFF.
REQ-026 SYNC, k differs from expected: set SEQERR, move to UNSYNC, TSTATE<=0.
REQ-027 ERREXP/ERRGOT capture the first SEQERR only and hold until ERRCLR or rst.
REQ-028 MGOJAM high: next state UNSYNC, TSTATE=0; this overrides any edge in the same cycle, raises no error, and leaves MCTCNT unchanged.
REQ-029 Stall counter clears on any rising edge and on MGOJAM, otherwise increments, saturating at STALL_LIM.
REQ-030 At STALL_LIM the counter asserts STALL if MSTPIT_=1 or STOPPED if MSTPIT_=0; both deassert in the cycle after the counter clears.
REQ-031 ERRCLR clears SEQERR, MULTERR, WIDERR, ERREXP and ERRGOT; a new error in the same cycle wins (flag set, capture loaded).
REQ-032 All outputs are registered; the response to an edge appears one cycle after the edge is detected.

Reset
REQ-033 rst=1: TSTATE=0, MCTCNT=0, all flags 0, ERREXP=ERRGOT=0, sample registers 0, stall counter 0, state UNSYNC.
REQ-034 rst dominates MGOJAM and ERRCLR; rst asserted mid-pulse causes an MT line already high after rst to produce no edge.

Configuration
REQ-035 Macro MTMON_WIDTH_EN defined: per-line high-time counters; on the falling edge, WIDERR is set if width < WMIN, and it is set as soon as width > WMAX.
REQ-036 Macro MTMON_WIDTH_EN absent: no width counters are built and WIDERR is tied to 0.

Structure
REQ-037 Package mtmon_pkg holds the 4-bit index typedef, the UNSYNC/SYNC state enum, constant NUM_TP=12, and the wrap function next_tp().
REQ-038 Sub-module mtmon_edge: 12-line sample register, rising-edge detect, one-hot-to-index encoder and multiple-edge flag.

Verification
REQ-039 Drive MT01..MT12 in order, 1 cycle each, for 3 cycles -> TSTATE steps 1..12, MCTCNT=2 (first MT01 only syncs), no flags.
REQ-040 Drive sequence 1,2,3,5 -> SEQERR=1, ERREXP=4, ERRGOT=5, TSTATE=0; a following 6 resyncs with no new error.
REQ-041 Pulse MT03 and MT07 in the same cycle -> MULTERR=1, TSTATE unchanged; then pulse ERRCLR -> MULTERR=0.
REQ-042 MGOJAM during MT06 after TSTATE=5 -> TSTATE=0, no SEQERR; then MT09 -> TSTATE=9, still no error.
REQ-043 Hold MT lines low for 16 cycles, first with MSTPIT_=1 and then with MSTPIT_=0 -> STALL=1, then STOPPED=1; the next edge clears both.
REQ-044 With MTMON_WIDTH_EN defined, hold MT04 high for 3 cycles -> WIDERR=1; without the macro, WIDERR stays 0.
